// File: rtl/lanzones_pkg.sv
// Shared types and constants for the memory-port arbiter.
package lanzones_pkg;

    // Transfer sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Identity of the requester that owns the memory port.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    // Read time-out applied when the instantiating level does not override it.
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester picker: fixed data priority or round-robin on ties.
module mem_arb_pick
    import lanzones_pkg::*;
#(
    parameter bit DPRIO = 1'b1
)(
    input  logic i_req,
    input  logic d_req,
    input  gnt_e last,
    output logic any_req,
    output gnt_e gnt
);

    // Choose the winner; a lone requester always wins, a tie follows DPRIO.
    always_comb begin
        any_req = i_req | d_req;
        gnt     = GNT_I;
        if (d_req && !i_req) begin
            gnt = GNT_D;
        end else if (d_req && i_req) begin
            if (DPRIO) begin
                gnt = GNT_D;
            end else begin
                gnt = (last == GNT_I) ? GNT_D : GNT_I;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
//
// Handshakes: IReq/DReq are level requests held with their address/data
// until the matching one-cycle Ack; requests are only looked at in IDLE and
// DONE absorbs the cycle in which the requester drops Req. On the memory
// side RRdy is held from grant until the registered RVld pulse (or the
// time-out), and RWEn is a single-cycle write strobe; the two never overlap.
module mem_port_arbiter
    import lanzones_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter bit DPRIO   = 1'b1,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IAck,
    output logic [DW-1:0] IData,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic          DAck,
    output logic [DW-1:0] DRData,
    output logic          RRdy,
    output logic          RWEn,
    output logic [AW-1:0] RAddr,
    output logic [DW-1:0] RWData,
    input  logic          RVld,
    input  logic [DW-1:0] RData,
    output logic          Busy,
    output logic          Err
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_e        state_q,  state_d;
    gnt_e          last_q,   last_d;
    gnt_e          gnt_q,    gnt_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic          rrdy_q,   rrdy_d;
    logic          rwen_q,   rwen_d;
    logic [AW-1:0] raddr_q,  raddr_d;
    logic [DW-1:0] rwdata_q, rwdata_d;
    logic          iack_q,   iack_d;
    logic [DW-1:0] idata_q,  idata_d;
    logic          dack_q,   dack_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          busy_q,   busy_d;
    logic          err_q,    err_d;

    logic pick_any;
    gnt_e pick_gnt;

    mem_arb_pick #(
        .DPRIO (DPRIO)
    ) u_pick (
        .i_req   (IReq),
        .d_req   (DReq),
        .last    (last_q),
        .any_req (pick_any),
        .gnt     (pick_gnt)
    );

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        timer_d  = timer_q;
        rrdy_d   = rrdy_q;
        rwen_d   = rwen_q;
        raddr_d  = raddr_q;
        rwdata_d = rwdata_q;
        iack_d   = 1'b0;
        idata_d  = idata_q;
        dack_d   = 1'b0;
        drdata_d = drdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    last_d  = pick_gnt;
                    raddr_d = (pick_gnt == GNT_D) ? DAddr : IAddr;
                    if (pick_gnt == GNT_D && DWe) begin
                        rwen_d   = 1'b1;
                        rwdata_d = DWData;
                        state_d  = WR;
                    end else begin
                        rrdy_d  = 1'b1;
                        timer_d = '0;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (RVld) begin
                    rrdy_d  = 1'b0;
                    state_d = DONE;
                    if (gnt_q == GNT_I) begin
                        iack_d  = 1'b1;
                        idata_d = RData;
                    end else begin
                        dack_d   = 1'b1;
                        drdata_d = RData;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Memory never answered: complete the transfer with zero
                    // data so the requester is not stuck, and flag it.
                    rrdy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (gnt_q == GNT_I) begin
                        iack_d  = 1'b1;
                        idata_d = '0;
                    end else begin
                        dack_d   = 1'b1;
                        drdata_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WR: begin
                rwen_d  = 1'b0;
                dack_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and all registered outputs; reset makes fetch win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= GNT_D;
            gnt_q    <= GNT_I;
            timer_q  <= '0;
            rrdy_q   <= 1'b0;
            rwen_q   <= 1'b0;
            raddr_q  <= '0;
            rwdata_q <= '0;
            iack_q   <= 1'b0;
            idata_q  <= '0;
            dack_q   <= 1'b0;
            drdata_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            timer_q  <= timer_d;
            rrdy_q   <= rrdy_d;
            rwen_q   <= rwen_d;
            raddr_q  <= raddr_d;
            rwdata_q <= rwdata_d;
            iack_q   <= iack_d;
            idata_q  <= idata_d;
            dack_q   <= dack_d;
            drdata_q <= drdata_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign IAck   = iack_q;
    assign IData  = idata_q;
    assign DAck   = dack_q;
    assign DRData = drdata_q;
    assign RRdy   = rrdy_q;
    assign RWEn   = rwen_q;
    assign RAddr  = raddr_q;
    assign RWData = rwdata_q;
    assign Busy   = busy_q;
    assign Err    = err_q;

    // Read request and write strobe must never be on the port together.
    assert property (@(posedge clk) disable iff (rst) !(rrdy_q && rwen_q));

    // Only one requester is acknowledged per transfer.
    assert property (@(posedge clk) disable iff (rst) !(iack_q && dack_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: data-priority instance plus a round-robin one.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT with data priority ----------------
    logic          i_req, i_ack, d_req, d_we, d_ack, r_rdy, r_wen, busy, err;
    logic [AW-1:0] i_addr, d_addr, r_addr;
    logic [DW-1:0] i_data, d_wdata, d_rdata, r_wdata;
    logic          r_vld  = 1'b0;
    logic [DW-1:0] r_data = '0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .DPRIO(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .IReq(i_req), .IAddr(i_addr), .IAck(i_ack), .IData(i_data),
        .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWData(d_wdata),
        .DAck(d_ack), .DRData(d_rdata),
        .RRdy(r_rdy), .RWEn(r_wen), .RAddr(r_addr), .RWData(r_wdata),
        .RVld(r_vld), .RData(r_data), .Busy(busy), .Err(err)
    );

    // ---------------- DUT with round-robin ----------------
    logic          rr_i_req, rr_i_ack, rr_d_req, rr_d_ack, rr_r_rdy, rr_r_wen, rr_busy, rr_err;
    logic [AW-1:0] rr_i_addr, rr_d_addr, rr_r_addr;
    logic [DW-1:0] rr_i_data, rr_d_rdata, rr_r_wdata;
    logic          rr_d_we    = 1'b0;
    logic [DW-1:0] rr_d_wdata = '0;
    logic          rr_r_vld   = 1'b0;
    logic [DW-1:0] rr_r_data  = '0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .DPRIO(1'b0), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst(rst),
        .IReq(rr_i_req), .IAddr(rr_i_addr), .IAck(rr_i_ack), .IData(rr_i_data),
        .DReq(rr_d_req), .DWe(rr_d_we), .DAddr(rr_d_addr), .DWData(rr_d_wdata),
        .DAck(rr_d_ack), .DRData(rr_d_rdata),
        .RRdy(rr_r_rdy), .RWEn(rr_r_wen), .RAddr(rr_r_addr), .RWData(rr_r_wdata),
        .RVld(rr_r_vld), .RData(rr_r_data), .Busy(rr_busy), .Err(rr_err)
    );

    // ---------------- memory contents ----------------
    function automatic logic [DW-1:0] init_word(input logic [8:0] a);
        if (a == 9'h100) return 32'h00500093;
        return {16'hA5C3, 7'd0, a};
    endfunction

    // Memory stubs: registered read answer one cycle after RRdy is seen.
    bit            mem_silent = 1'b0;
    bit            stray      = 1'b0;
    logic [DW-1:0] st_mem [0:511];
    bit            st_wr  [0:511];

    always @(posedge clk) begin
        r_vld <= 1'b0;
        if (stray) begin
            r_vld  <= 1'b1;
            r_data <= 32'hDEADBEEF;
        end else if (r_rdy && !r_vld && !mem_silent) begin
            r_vld  <= 1'b1;
            r_data <= st_wr[r_addr[8:0]] ? st_mem[r_addr[8:0]] : init_word(r_addr[8:0]);
        end
        if (r_wen) begin
            st_mem[r_addr[8:0]] <= r_wdata;
            st_wr[r_addr[8:0]]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        rr_r_vld <= 1'b0;
        if (rr_r_rdy && !rr_r_vld) begin
            rr_r_vld  <= 1'b1;
            rr_r_data <= init_word(rr_r_addr[8:0]);
        end
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    exp_t          i_exp_q [$];
    exp_t          d_exp_q [$];
    logic [DW-1:0] ref_mem [0:511];
    bit            ref_wr  [0:511];

    function automatic logic [DW-1:0] ref_read(input logic [8:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        rr_i_req = 0; rr_i_addr = '0; rr_d_req = 0; rr_d_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({r_rdy, r_wen, i_ack, d_ack, busy, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {r_rdy, r_wen, i_ack, d_ack, busy, err});
        end
        checks++;
        if ({r_addr, r_wdata, i_data, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want all 0", r_addr, r_wdata, i_data, d_rdata);
        end
        checks++;
        if ({rr_r_rdy, rr_r_wen, rr_i_ack, rr_d_ack, rr_busy, rr_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_rr got %b want 000000", {rr_r_rdy, rr_r_wen, rr_i_ack, rr_d_ack, rr_busy, rr_err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_fetch();
        exp_t e;
        i_req = 1'b1; i_addr = 32'h100;
        i_exp_q.push_back('{chk: 1'b1, data: ref_read(9'h100)});
        @(negedge clk); // cycle 1
        checks++;
        if ({r_rdy, r_wen, busy} !== 3'b101 || r_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_c1 got rrdy/rwen/busy %b addr %h want 101 100", {r_rdy, r_wen, busy}, r_addr);
        end
        @(negedge clk); // cycle 2
        checks++;
        if ({r_rdy, i_ack} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_c2 got rrdy/iack %b want 10", {r_rdy, i_ack});
        end
        @(negedge clk); // cycle 3
        checks++;
        if ({r_rdy, i_ack} !== 2'b01) begin
            errors++;
            $display("FAIL fetch_c3 got rrdy/iack %b want 01", {r_rdy, i_ack});
        end
        if (i_exp_q.size() != 0) begin
            e = i_exp_q.pop_front();
            checks++;
            if (i_data !== e.data) begin
                errors++;
                $display("FAIL fetch_data got %h want %h", i_data, e.data);
            end
        end
        i_req = 1'b0;
        @(negedge clk); // cycle 4
        checks++;
        if ({busy, i_ack, err} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_c4 got busy/iack/err %b want 000", {busy, i_ack, err});
        end
    endtask

    task automatic test_store_load();
        exp_t e;
        int   cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h105; d_wdata = 32'hCAFEF00D;
        ref_mem[9'h105] = 32'hCAFEF00D; ref_wr[9'h105] = 1'b1;
        d_exp_q.push_back('{chk: 1'b0, data: '0});
        @(negedge clk); // cycle 1
        checks++;
        if ({r_wen, r_rdy} !== 2'b10 || r_addr !== 32'h105 || r_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL store_c1 got rwen/rrdy %b addr %h wdata %h want 10 105 cafef00d", {r_wen, r_rdy}, r_addr, r_wdata);
        end
        @(negedge clk); // cycle 2
        checks++;
        if ({d_ack, r_wen} !== 2'b10) begin
            errors++;
            $display("FAIL store_c2 got dack/rwen %b want 10", {d_ack, r_wen});
        end
        if (d_ack && d_exp_q.size() != 0) e = d_exp_q.pop_front();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk); // cycle 3
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL store_c3 busy got %b want 0", busy);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h105;
        d_exp_q.push_back('{chk: 1'b1, data: ref_read(9'h105)});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!d_ack && cyc < 10);
        checks++;
        if (!d_ack || cyc != 3) begin
            errors++;
            $display("FAIL load_lat got cycle %0d ack %b want cycle 3", cyc, d_ack);
        end
        if (d_ack && d_exp_q.size() != 0) begin
            e = d_exp_q.pop_front();
            checks++;
            if (d_rdata !== e.data) begin
                errors++;
                $display("FAIL load_data got %h want %h", d_rdata, e.data);
            end
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_tie(input bit on_rr, input int exp_d_at, input int exp_i_at, input string name);
        int   d_at = -1;
        int   i_at = -1;
        exp_t e;
        if (on_rr) begin
            rr_i_req = 1'b1; rr_i_addr = 32'h10; rr_d_req = 1'b1; rr_d_addr = 32'h101;
        end else begin
            i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h101;
        end
        i_exp_q.push_back('{chk: 1'b1, data: ref_read(9'h010)});
        d_exp_q.push_back('{chk: 1'b1, data: ref_read(9'h101)});
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (on_rr ? rr_d_ack : d_ack) begin
                d_at = c;
                checks++;
                if (d_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_dup_dack got extra ack want none", name);
                end else begin
                    e = d_exp_q.pop_front();
                    if ((on_rr ? rr_d_rdata : d_rdata) !== e.data) begin
                        errors++;
                        $display("FAIL %s_ddata got %h want %h", name, on_rr ? rr_d_rdata : d_rdata, e.data);
                    end
                end
                d_req = 1'b0; rr_d_req = 1'b0;
            end
            if (on_rr ? rr_i_ack : i_ack) begin
                i_at = c;
                checks++;
                if (i_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_dup_iack got extra ack want none", name);
                end else begin
                    e = i_exp_q.pop_front();
                    if ((on_rr ? rr_i_data : i_data) !== e.data) begin
                        errors++;
                        $display("FAIL %s_idata got %h want %h", name, on_rr ? rr_i_data : i_data, e.data);
                    end
                end
                i_req = 1'b0; rr_i_req = 1'b0;
            end
        end
        checks++;
        if (d_at != exp_d_at || i_at != exp_i_at) begin
            errors++;
            $display("FAIL %s_order got dack@%0d iack@%0d want dack@%0d iack@%0d", name, d_at, i_at, exp_d_at, exp_i_at);
        end
    endtask

    task automatic test_tie_dprio();
        run_tie(1'b0, 3, 7, "tie_dprio");
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   cyc;
        run_tie(1'b1, 7, 3, "rr_first");
        // A lone fetch makes fetch the last grant, so the next tie goes to data.
        rr_i_req = 1'b1; rr_i_addr = 32'h44;
        i_exp_q.push_back('{chk: 1'b1, data: ref_read(9'h044)});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rr_i_ack && cyc < 10);
        checks++;
        if (!rr_i_ack || i_exp_q.size() == 0) begin
            errors++;
            $display("FAIL rr_single got ack %b after %0d cycles want ack", rr_i_ack, cyc);
        end else begin
            e = i_exp_q.pop_front();
            if (rr_i_data !== e.data) begin
                errors++;
                $display("FAIL rr_single_data got %h want %h", rr_i_data, e.data);
            end
        end
        rr_i_req = 1'b0;
        repeat (2) @(negedge clk);
        run_tie(1'b1, 3, 7, "rr_second");
    endtask

    task automatic test_timeout();
        exp_t e;
        int   bad = 0;
        mem_silent = 1'b1;
        i_req = 1'b1; i_addr = 32'h20;
        i_exp_q.push_back('{chk: 1'b1, data: '0});
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            if (r_rdy !== 1'b1 || i_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_wait got %0d bad RD_WAIT cycles want 0", bad);
        end
        @(negedge clk);
        checks++;
        if ({r_rdy, i_ack, err} !== 3'b011) begin
            errors++;
            $display("FAIL timeout_end got rrdy/iack/err %b want 011", {r_rdy, i_ack, err});
        end
        if (i_ack && i_exp_q.size() != 0) begin
            e = i_exp_q.pop_front();
            checks++;
            if (i_data !== e.data) begin
                errors++;
                $display("FAIL timeout_data got %h want %h", i_data, e.data);
            end
        end
        i_req = 1'b0;
        mem_silent = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_sticky got err/busy %b want 10", {err, busy});
        end
    endtask

    task automatic test_reset_mid_read();
        exp_t e;
        int   bad = 0;
        int   cyc;
        i_req = 1'b1; i_addr = 32'h30;
        @(negedge clk);
        checks++;
        if (r_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre rrdy got %b want 1", r_rdy);
        end
        #2;
        rst = 1'b1; i_req = 1'b0;
        #1;
        checks++;
        if ({r_rdy, i_ack, busy, err} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async got rrdy/iack/busy/err %b want 0000", {r_rdy, i_ack, busy, err});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack || busy || r_rdy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_stray got %0d reacting cycles want 0", bad);
        end
        i_req = 1'b1; i_addr = 32'h30;
        i_exp_q.push_back('{chk: 1'b1, data: ref_read(9'h030)});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!i_ack && cyc < 10);
        checks++;
        if (!i_ack || cyc != 3) begin
            errors++;
            $display("FAIL midrst_retry got cycle %0d ack %b want cycle 3", cyc, i_ack);
        end
        if (i_ack && i_exp_q.size() != 0) begin
            e = i_exp_q.pop_front();
            checks++;
            if (i_data !== e.data) begin
                errors++;
                $display("FAIL midrst_data got %h want %h", i_data, e.data);
            end
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stress();
        int   issued = 0;
        int   cyc    = 0;
        int   both   = 0;
        exp_t e;
        while ((issued < 200 || i_exp_q.size() != 0 || d_exp_q.size() != 0) && cyc < 4000) begin
            bit            i_done;
            bit            d_done;
            logic [8:0]    a;
            logic [DW-1:0] w;
            i_done = 1'b0;
            d_done = 1'b0;
            @(negedge clk);
            cyc++;
            if (r_rdy && r_wen) both++;
            if (i_ack) begin
                i_done = 1'b1;
                checks++;
                if (i_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stress_iack got unexpected ack want none at cycle %0d", cyc);
                end else begin
                    e = i_exp_q.pop_front();
                    if (i_data !== e.data) begin
                        errors++;
                        $display("FAIL stress_idata got %h want %h", i_data, e.data);
                    end
                end
                i_req = 1'b0;
            end
            if (d_ack) begin
                d_done = 1'b1;
                checks++;
                if (d_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stress_dack got unexpected ack want none at cycle %0d", cyc);
                end else begin
                    e = d_exp_q.pop_front();
                    if (e.chk && d_rdata !== e.data) begin
                        errors++;
                        $display("FAIL stress_ddata got %h want %h", d_rdata, e.data);
                    end
                end
                d_req = 1'b0;
            end
            if (!i_req && !i_done && issued < 200 && $urandom_range(0, 2) == 0) begin
                a = {1'b0, 8'($urandom_range(0, 255))};
                i_req = 1'b1; i_addr = {23'd0, a};
                i_exp_q.push_back('{chk: 1'b1, data: ref_read(a)});
                issued++;
            end
            if (!d_req && !d_done && issued < 200 && $urandom_range(0, 2) == 0) begin
                a = {1'b1, 8'($urandom_range(0, 255))};
                d_req = 1'b1; d_addr = {23'd0, a};
                d_we = 1'($urandom_range(0, 1));
                if (d_we) begin
                    w = $urandom;
                    d_wdata = w;
                    ref_mem[a] = w; ref_wr[a] = 1'b1;
                    d_exp_q.push_back('{chk: 1'b0, data: '0});
                end else begin
                    d_exp_q.push_back('{chk: 1'b1, data: ref_read(a)});
                end
                issued++;
            end
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL stress_overlap got %0d cycles with RRdy&RWEn want 0", both);
        end
        checks++;
        if (issued != 200 || i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            errors++;
            $display("FAIL stress_complete got issued %0d pending %0d/%0d after %0d cycles want 200 0/0",
                     issued, i_exp_q.size(), d_exp_q.size(), cyc);
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_tie_dprio();
        test_round_robin();
        test_timeout();
        test_reset_mid_read();
        test_stress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
